// File: rtl/mul16_acc_if.sv
// mul16_acc_if
// Run/done handshake bundle for the sequential multiply-accumulate unit.
// The master side (controller or bench) drives in_run and the three
// operands. The slave side (mul16_acc) returns the result, the done flag
// and a copy of its clock.
//
// Signals:
//   in_run     master->slave  low = hold in restart, high = run / hold result
//   in_a       master->slave  16-bit multiplier, sampled in LOAD only
//   in_b       master->slave  16-bit multiplicand, sampled in LOAD only
//   in_c       master->slave  16-bit addend, sampled in LOAD only
//   out_ret    slave->master  32-bit result, valid while out_done=1
//   out_done   slave->master  high when the unit is in DONE
//   out_clock  slave->master  copy of the unit clock
interface mul16_acc_if;
    logic        in_run;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_c;
    logic [31:0] out_ret;
    logic        out_done;
    logic        out_clock;

    modport master (
        output in_run,
        output in_a,
        output in_b,
        output in_c,
        input  out_ret,
        input  out_done,
        input  out_clock
    );

    modport slave (
        input  in_run,
        input  in_a,
        input  in_b,
        input  in_c,
        output out_ret,
        output out_done,
        output out_clock
    );
endinterface

// File: rtl/mul16_acc.sv
// mul16_acc
// Sequential unsigned multiply-accumulate: out_ret = in_a * in_b + in_c.
// The product is formed MSB-first by shift-and-add over 16 iterations, and
// the addend is folded in during a single FINISH cycle. Its main use is to
// rebuild a numerator from the quotient, divisor and remainder of div16, so
// it shares the divider's run/done handshake.
//
// Ports:
//   clock  input   sole clock, all state updates on the rising edge
//   reset  input   asynchronous, active-high; forces DONE with a zero result
//   bus    slave   mul16_acc_if: in_run, in_a, in_b, in_c, out_ret,
//                  out_done, out_clock
//
// Sequence: in_run low parks the unit in LOAD and clears the result.
// Raising in_run samples the operands in LOAD, runs 16 ITER cycles and
// one FINISH cycle, then holds the result in DONE while in_run stays high.
// The done flag therefore rises 18 cycles after the first LOAD edge.
module mul16_acc (
    input  logic       clock,
    input  logic       reset,
    mul16_acc_if.slave bus
);

    localparam int DATA_W = 16;
    localparam int ACC_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4:0]          i;
    logic [4:0]          i_nxt;
    logic [DATA_W-1:0]   a_sh;
    logic [DATA_W-1:0]   a_sh_nxt;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   b_q_nxt;
    logic [DATA_W-1:0]   c_q;
    logic [DATA_W-1:0]   c_q_nxt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_nxt;
    logic [ACC_W-1:0]    ret;
    logic [ACC_W-1:0]    ret_nxt;

    // One MSB-first shift-and-add step. The accumulator is doubled and the
    // multiplicand added when the current multiplier bit is set. After 16
    // steps acc holds the full product; it never exceeds 32 bits.
    function automatic logic [ACC_W-1:0] mac_step(
        input logic [ACC_W-1:0]  acc_in,
        input logic              a_msb,
        input logic [DATA_W-1:0] b_in
    );
        logic [ACC_W-1:0] addend;
        addend   = a_msb ? {{DATA_W{1'b0}}, b_in} : {ACC_W{1'b0}};
        mac_step = {acc_in[ACC_W-2:0], 1'b0} + addend;
    endfunction

    // Final addend fold. 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000, so the
    // modulo-2^32 sum can never actually wrap.
    function automatic logic [ACC_W-1:0] add_addend(
        input logic [ACC_W-1:0]  acc_in,
        input logic [DATA_W-1:0] c_in
    );
        add_addend = acc_in + {{DATA_W{1'b0}}, c_in};
    endfunction

    // Next-state and datapath update. in_run low overrides every state so a
    // run in progress is abandoned and no partial product reaches ret.
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        a_sh_nxt  = a_sh;
        b_q_nxt   = b_q;
        c_q_nxt   = c_q;
        acc_nxt   = acc;
        ret_nxt   = ret;

        if (!bus.in_run) begin
            state_nxt = LOAD;
            i_nxt     = 5'd0;
            ret_nxt   = {ACC_W{1'b0}};
        end else begin
            case (state)
                LOAD: begin
                    a_sh_nxt  = bus.in_a;
                    b_q_nxt   = bus.in_b;
                    c_q_nxt   = bus.in_c;
                    acc_nxt   = {ACC_W{1'b0}};
                    i_nxt     = 5'd0;
                    state_nxt = ITER;
                end
                ITER: begin
                    acc_nxt  = mac_step(acc, a_sh[DATA_W-1], b_q);
                    a_sh_nxt = {a_sh[DATA_W-2:0], 1'b0};
                    i_nxt    = i + 5'd1;
                    // i counts completed steps; the 16th step is taken
                    // when i enters as 15.
                    if (i == 5'd15) begin
                        state_nxt = FINISH;
                    end
                end
                FINISH: begin
                    ret_nxt   = add_addend(acc, c_q);
                    state_nxt = DONE;
                end
                DONE: begin
                    // Hold the result until in_run is sampled low.
                end
            endcase
        end
    end

    // Control and result registers: cleared asynchronously so the unit
    // reports done with a zero result the moment reset is asserted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DONE;
            i     <= 5'd0;
            acc   <= {ACC_W{1'b0}};
            ret   <= {ACC_W{1'b0}};
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            acc   <= acc_nxt;
            ret   <= ret_nxt;
        end
    end

    // Operand holding registers: only meaningful after LOAD, so they carry
    // no reset.
    always_ff @(posedge clock) begin
        a_sh <= a_sh_nxt;
        b_q  <= b_q_nxt;
        c_q  <= c_q_nxt;
    end

    assign bus.out_ret   = ret;
    assign bus.out_done  = (state == DONE);
    assign bus.out_clock = clock;

endmodule

// File: tb/tb_mul16_acc.sv
// tb_mul16_acc
// Self-checking bench for mul16_acc: a table of directed operand triples,
// hand-written restart and asynchronous-reset sequences, and a random run
// against the a*b+c reference model. Expected results go into a queue when
// a run is started and are popped when out_done rises.
module tb_mul16_acc;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mul16_acc_if bus ();

    mul16_acc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [31:0] expv;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    // Standard start: in_run low for one edge with operands stable, then
    // raised. The next rising edge is L.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [31:0] expv);
        @(posedge clock); #1;
        bus.in_run = 1'b0;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_c   = c;
        @(posedge clock); #1;
        check("done_drop", {31'b0, bus.out_done}, 32'd0);
        bus.in_run = 1'b1;
        sb_q.push_back(expv);
    endtask

    // Counts edges from L until out_done, optionally scrambling the operand
    // inputs after every edge, then compares latency, the zero result while
    // busy and the scoreboard entry.
    task automatic wait_done(input bit scramble, input string tag);
        int          lat;
        bit          zero_ok;
        logic [31:0] expv;
        lat     = 0;
        zero_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (scramble) begin
                bus.in_a = 16'($urandom);
                bus.in_b = 16'($urandom);
                bus.in_c = 16'($urandom);
            end
            if (bus.out_done) begin
                lat = k;
                break;
            end
            if (bus.out_ret !== 32'd0) zero_ok = 1'b0;
        end
        check($sformatf("%s_latency", tag), lat, 32'd18);
        check($sformatf("%s_ret_zero_busy", tag), {31'b0, zero_ok}, 32'd1);
        if (sb_q.size() == 0) begin
            check($sformatf("%s_scoreboard_empty", tag), 32'd0, 32'd1);
        end else begin
            expv = sb_q.pop_front();
            check($sformatf("%s_ret", tag), bus.out_ret, expv);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rc;
        bit          zero_ok;

        vecs[0] = '{a: 16'd488,   b: 16'd41,    c: 16'd35,    expv: 32'h0000_4E4B};
        vecs[1] = '{a: 16'hFFFF,  b: 16'hFFFF,  c: 16'hFFFF,  expv: 32'hFFFF_0000};
        vecs[2] = '{a: 16'hFFFF,  b: 16'h0001,  c: 16'h0000,  expv: 32'h0000_FFFF};
        vecs[3] = '{a: 16'd0,     b: 16'd1234,  c: 16'd0,     expv: 32'd0};
        vecs[4] = '{a: 16'd1,     b: 16'd0,     c: 16'd7,     expv: 32'd7};

        reset      = 1'b1;
        bus.in_run = 1'b1;
        bus.in_a   = 16'd0;
        bus.in_b   = 16'd0;
        bus.in_c   = 16'd0;

        // Reset state before any clock edge: async reset alone sets DONE.
        #2;
        check("reset_done", {31'b0, bus.out_done}, 32'd1);
        check("reset_ret", bus.out_ret, 32'd0);

        @(negedge clock);
        check("out_clock_low", {31'b0, bus.out_clock}, 32'd0);
        @(posedge clock); #1;
        check("out_clock_high", {31'b0, bus.out_clock}, 32'd1);
        reset = 1'b0;

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            start_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].expv);
            wait_done(1'b0, $sformatf("vec%0d", v));
        end

        // Restart mid-ITER: run 3*5 is abandoned at ITER cycle 8 and 6*7+1
        // starts instead. The abandoned 15 must never appear.
        @(posedge clock); #1;
        bus.in_run = 1'b0;
        bus.in_a   = 16'd3;
        bus.in_b   = 16'd5;
        bus.in_c   = 16'd0;
        @(posedge clock); #1;
        bus.in_run = 1'b1;
        zero_ok    = 1'b1;
        repeat (9) begin
            @(posedge clock); #1;
            if (bus.out_ret !== 32'd0 || bus.out_done) zero_ok = 1'b0;
        end
        check("restart_first_run_busy", {31'b0, zero_ok}, 32'd1);
        bus.in_run = 1'b0;
        bus.in_a   = 16'd6;
        bus.in_b   = 16'd7;
        bus.in_c   = 16'd1;
        @(posedge clock); #1;
        check("restart_done_low", {31'b0, bus.out_done}, 32'd0);
        check("restart_ret_low", bus.out_ret, 32'd0);
        bus.in_run = 1'b1;
        sb_q.push_back(32'd43);
        wait_done(1'b0, "restart");

        // Asynchronous reset between edges in the middle of ITER.
        start_op(16'd9, 16'd9, 16'd9, 32'd0);
        void'(sb_q.pop_back());
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_done", {31'b0, bus.out_done}, 32'd1);
        check("async_reset_ret", bus.out_ret, 32'd0);
        @(posedge clock); #1;
        reset      = 1'b0;
        bus.in_run = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_reset_hold_done", {31'b0, bus.out_done}, 32'd1);
        check("post_reset_hold_ret", bus.out_ret, 32'd0);
        start_op(16'd100, 16'd200, 16'd5, 32'd20005);
        wait_done(1'b0, "after_reset");

        // Random triples with operand inputs scrambled after L.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 16'($urandom);
            start_op(ra, rb, rc, ({16'd0, ra} * {16'd0, rb}) + {16'd0, rc});
            wait_done(1'b1, "rand");
        end

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul16_acc.md
# mul16_acc

Sequential unsigned 16x16 multiply-accumulate, out_ret = in_a * in_b + in_c, computed MSB-first shift-and-add over 16 iterations. It is the inverse of the 16-bit restoring divider: feeding it quotient, divisor and remainder rebuilds the numerator, so main can self-check division results. It uses the same run/done handshake as the divider, and is instantiated beside div16 under M_main.

## Interface
Parameters: none. Widths are fixed at 16-bit operands and a 32-bit result.

- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces DONE state
- in_run  input  1  low = hold in restart; high = run/hold result
- in_a  input  16  multiplier (unsigned), sampled in LOAD only
- in_b  input  16  multiplicand (unsigned), sampled in LOAD only
- in_c  input  16  addend (unsigned), sampled in LOAD only
- out_ret  output  32  result; valid while out_done=1 after a completed run
- out_done  output  1  high when state==DONE
- out_clock  output  1  equals clock

## Operation
- Registers:
  - state: 2 bits (LOAD=0, ITER=1, FINISH=2, DONE=3)
  - i: 5 bits
  - a_sh: 16 bits
  - b_q, c_q: 16 bits each
  - acc: 32 bits
  - ret: 32 bits, drives out_ret
- Reset (async): state=DONE, i=0, acc=0, ret=0. Result: out_done=1, out_ret=0.
- in_run=0 (reset low): next state=LOAD, i=0, ret=0. Overrides any in-progress run; operands are not latched.
- LOAD (in_run=1): a_sh=in_a, b_q=in_b, c_q=in_c, acc=0, i=0, then go to ITER.
- ITER, each cycle:
  - acc = (acc<<1) + (a_sh[15] ? {16'b0,b_q} : 0)
  - a_sh = a_sh<<1
  - i = i+1
  - When i==15 on entry, go to FINISH; otherwise stay in ITER.
- FINISH: ret = acc + {16'b0,c_q}, then go to DONE.
- DONE: hold ret and stay while in_run=1. in_run falling to 0 starts a new run.
- Arithmetic is unsigned modulo 2^32. The maximum result, 0xFFFF*0xFFFF+0xFFFF = 0xFFFF0000, never overflows.
- Input changes after LOAD have no effect on the current run.

## Timing
- Let cycle L be the first rising edge with state=LOAD and in_run=1. Then:
  - ITER occupies edges L+1..L+16
  - FINISH is edge L+17
  - out_done=1 and out_ret is valid after edge L+17, i.e. 18 cycles after L
- Standard start: hold in_run=0 for ≥1 cycle with operands stable through edge L, then raise in_run. Total latency from the rising in_run edge to out_done is 18 cycles.
- out_done drops the cycle after in_run is sampled low, and stays low until FINISH completes.
- out_ret reads 0 from the in_run-low cycle until FINISH.
- Reset asserted mid-run aborts immediately (async): out_done=1, out_ret=0. After reset releases, the block stays in DONE until in_run is sampled low.
- in_run low mid-ITER restarts the run from LOAD. No partial result ever appears on out_ret.
- Simultaneous reset and in_run=0: reset wins, state=DONE.

## Test plan
- a=488, b=41, c=35, standard start -> out_done rises exactly 18 cycles after in_run rises, out_ret=20043 (0x00004E4B).
- a=0xFFFF, b=0xFFFF, c=0xFFFF -> out_ret=0xFFFF0000. Also a=0xFFFF, b=1, c=0 -> out_ret=0x0000FFFF.
- a=0, b=1234, c=0 -> out_ret=0. Then a=1, b=0, c=7 -> out_ret=7, confirming in_c is added only in FINISH.
- Start with a=3, b=5, c=0, then at ITER cycle 8 drop in_run for 1 cycle with a=6, b=7, c=1 -> out_ret=43 exactly 18 cycles after in_run rises again. out_ret must read 0 throughout, never 15.
- Assert reset asynchronously (between edges) mid-ITER -> out_done=1 and out_ret=0 immediately, before the next edge. After release with in_run=1, the state holds DONE. A subsequent standard start with a=100, b=200, c=5 -> out_ret=20005.
- Change in_a, in_b, in_c randomly every cycle after L -> result equals the product of the values sampled at L. Repeat for 1000 random triples against the reference model a*b+c.
